// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_sched
//  Description : Round-robin scheduler feeding one byte per frame from four
//                requesters into a UART transmit engine. Freezes the line
//                configuration for the duration of a frame, waits for the
//                engine's end-of-frame pulse (with timeout), then inserts an
//                idle gap before serving the next request.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_sched #(
  parameter int TIMEOUT = 2000000,
  parameter int GAP_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [31:0] req_data,
  output logic [3:0]  gnt,
  output logic        tx_load,
  output logic [7:0]  tx_data,
  input  logic        tx_done,
  input  logic [3:0]  cfg_baud,
  input  logic        cfg_eight,
  input  logic        cfg_parity_en,
  input  logic        cfg_ohel,
  output logic [3:0]  baud,
  output logic        eight,
  output logic        parity_en,
  output logic        ohel,
  output logic        busy,
  input  logic        err_clr,
  output logic        timeout_err
);

  // One counter serves both the done-timeout and the inter-frame gap.
  localparam int CNT_MAX = (TIMEOUT > GAP_CYC) ? TIMEOUT : GAP_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = (GAP_CYC > 0) ? CNT_W'(GAP_CYC - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LOAD      = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_GAP       = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       last_q, last_d;
  logic [1:0]       win_q, win_d;
  logic [3:0]       gnt_q, gnt_d;
  logic             tx_load_q, tx_load_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             err_q, err_d;
  logic [6:0]       cfg_q, cfg_d;

  logic             rr_found;
  logic [1:0]       rr_win;
  logic [1:0]       rr_idx;

  // Round-robin pick: first asserted request after the last one served.
  always_comb begin
    rr_found = 1'b0;
    rr_win   = 2'd0;
    rr_idx   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      rr_idx = last_q + 2'(k);
      if (!rr_found && req[rr_idx]) begin
        rr_found = 1'b1;
        rr_win   = rr_idx;
      end
    end
  end

  // Next-state and registered-output decode for the frame sequencer.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    win_d     = win_q;
    gnt_d     = 4'b0000;
    tx_load_d = 1'b0;
    tx_data_d = tx_data_q;
    cfg_d     = cfg_q;
    err_d     = err_clr ? 1'b0 : err_q;

    case (state_q)
      S_IDLE: begin
        // Configuration tracks the inputs only between frames.
        cfg_d = {cfg_baud, cfg_eight, cfg_parity_en, cfg_ohel};
        if (rr_found) begin
          win_d     = rr_win;
          tx_data_d = req_data[8*rr_win +: 8];
          gnt_d     = 4'b0001 << rr_win;
          tx_load_d = 1'b1;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        last_d  = win_q;
        cnt_d   = '0;
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (tx_done || (cnt_q == TO_LAST)) begin
          // A done pulse on the final cycle still counts as a clean finish.
          if (!tx_done) begin
            err_d = 1'b1;
          end
          cnt_d   = '0;
          state_d = (GAP_CYC == 0) ? S_IDLE : S_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      last_q    <= 2'd3;
      win_q     <= 2'd0;
      gnt_q     <= 4'b0000;
      tx_load_q <= 1'b0;
      tx_data_q <= 8'h00;
      err_q     <= 1'b0;
      cfg_q     <= 7'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      win_q     <= win_d;
      gnt_q     <= gnt_d;
      tx_load_q <= tx_load_d;
      tx_data_q <= tx_data_d;
      err_q     <= err_d;
      cfg_q     <= cfg_d;
    end
  end

  assign gnt         = gnt_q;
  assign tx_load     = tx_load_q;
  assign tx_data     = tx_data_q;
  assign timeout_err = err_q;
  assign {baud, eight, parity_en, ohel} = cfg_q;
  assign busy        = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_sched
//  Description : Self-checking bench for uart_tx_sched: reset values, a table
//                of directed frames, hand-written corner sequences and random
//                frames checked against a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_sched;

  localparam int TIMEOUT = 8;
  localparam int GAP_CYC = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic        tx_load;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic [3:0]  cfg_baud;
  logic        cfg_eight;
  logic        cfg_parity_en;
  logic        cfg_ohel;
  logic [3:0]  baud;
  logic        eight;
  logic        parity_en;
  logic        ohel;
  logic        busy;
  logic        err_clr;
  logic        timeout_err;

  logic [6:0]  applied;
  logic [6:0]  cfg_in;
  assign applied = {baud, eight, parity_en, ohel};
  assign cfg_in  = {cfg_baud, cfg_eight, cfg_parity_en, cfg_ohel};

  always #5 clk = ~clk;

  uart_tx_sched #(.TIMEOUT(TIMEOUT), .GAP_CYC(GAP_CYC)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
    .tx_load(tx_load), .tx_data(tx_data), .tx_done(tx_done),
    .cfg_baud(cfg_baud), .cfg_eight(cfg_eight), .cfg_parity_en(cfg_parity_en),
    .cfg_ohel(cfg_ohel), .baud(baud), .eight(eight), .parity_en(parity_en),
    .ohel(ohel), .busy(busy), .err_clr(err_clr), .timeout_err(timeout_err)
  );

  int   total = 0;
  int   bad   = 0;
  int   last_m;     // reference: index of the requester served last
  logic err_m;      // reference: sticky timeout flag

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference arbitration: first requester after the last served, wrapping.
  function automatic int rr_model(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  // Busy cycles of one frame: LOAD + wait-for-done (or full timeout) + gap.
  function automatic int frame_len(input int dly);
    if (dly >= 0 && dly < TIMEOUT) return 1 + (dly + 1) + GAP_CYC;
    return 1 + TIMEOUT + GAP_CYC;
  endfunction

  // Runs one frame from an idle DUT at a negedge. dly = wait cycle on which
  // tx_done pulses (-1 never); clr_at = busy-cycle index carrying err_clr;
  // mode 0 keeps cfg steady, 1 randomises it every cycle, 2 moves baud to 0011.
  task automatic do_frame(input logic [3:0] r, input logic [31:0] d, input int dly,
                          input int clr_at, input int mode, input logic [3:0] exp_g,
                          input logic [7:0] exp_b, input string tag);
    logic [6:0] cfg_exp;
    int cyc, len, loads, gnts;
    bit to;
    req      = r;
    req_data = d;
    cfg_exp  = cfg_in;
    @(negedge clk);
    chk({tag, ".gnt"}, 32'(gnt), 32'(exp_g));
    chk({tag, ".tx_load"}, 32'(tx_load), 32'd1);
    chk({tag, ".tx_data"}, 32'(tx_data), 32'(exp_b));
    req = 4'b0000;
    cyc = 0; len = 0; loads = 0; gnts = 0;
    while (busy === 1'b1 && cyc < 200) begin
      len++;
      if (tx_load === 1'b1) loads++;
      if (gnt !== 4'b0000) gnts++;
      chk({tag, ".cfg_frozen"}, 32'(applied), 32'(cfg_exp));
      tx_done = (dly >= 0 && cyc == dly + 1);
      err_clr = (cyc == clr_at);
      if (mode == 1) {cfg_baud, cfg_eight, cfg_parity_en, cfg_ohel} = 7'($urandom);
      if (mode == 2 && cyc == 2) cfg_baud = 4'b0011;
      @(negedge clk);
      cyc++;
    end
    tx_done = 1'b0;
    err_clr = 1'b0;
    if (cyc >= 200) begin
      bad++;
      $display("FAIL %s.busy_bound: busy still high after %0d cycles", tag, cyc);
    end
    to = !(dly >= 0 && dly < TIMEOUT);
    if (to) err_m = (clr_at > TIMEOUT) ? 1'b0 : 1'b1;
    else if (clr_at >= 0) err_m = 1'b0;
    for (int i = 0; i < 4; i++) if (exp_g[i]) last_m = i;
    chk({tag, ".busy_len"}, 32'(len), 32'(frame_len(dly)));
    chk({tag, ".loads"}, 32'(loads), 32'd1);
    chk({tag, ".gnts"}, 32'(gnts), 32'd1);
    chk({tag, ".timeout_err"}, 32'(timeout_err), 32'(err_m));
    chk({tag, ".cfg_idle0"}, 32'(applied), 32'(cfg_exp));
    @(negedge clk);
    chk({tag, ".cfg_reload"}, 32'(applied), 32'(cfg_in));
    chk({tag, ".idle_out"}, 32'({busy, tx_load, gnt}), 32'd0);
  endtask

  typedef struct {
    logic [3:0]  r;
    logic [31:0] d;
    int          dly;
    logic [3:0]  exp_g;
    logic [7:0]  exp_b;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    // Directed frames starting from the reset pointer (requester 0 first).
    tbl[0] = '{4'b0010, 32'h0000_AE00, 2, 4'b0010, 8'hAE};
    tbl[1] = '{4'b1111, 32'h4433_2211, 0, 4'b0100, 8'h33};
    tbl[2] = '{4'b1111, 32'h8877_6655, 5, 4'b1000, 8'h88};
    tbl[3] = '{4'b1111, 32'hCCBB_AA99, 7, 4'b0001, 8'h99};
    tbl[4] = '{4'b0001, 32'h0000_00F0, 1, 4'b0001, 8'hF0};
    tbl[5] = '{4'b1001, 32'h5A00_00A5, 3, 4'b1000, 8'h5A};
    tbl[6] = '{4'b1001, 32'h5A00_00A5, 0, 4'b0001, 8'hA5};
    tbl[7] = '{4'b0110, 32'h00C3_D200, 4, 4'b0010, 8'hD2};
    tbl[8] = '{4'b0100, 32'h007E_0000, 6, 4'b0100, 8'h7E};
    tbl[9] = '{4'b1111, 32'h1234_5678, 1, 4'b1000, 8'h12};

    rst = 1'b1; req = 4'b0000; req_data = 32'h0; tx_done = 1'b0; err_clr = 1'b0;
    {cfg_baud, cfg_eight, cfg_parity_en, cfg_ohel} = 7'h5B;
    repeat (3) @(negedge clk);
    req = 4'b1111;
    @(negedge clk);
    chk("rst.gnt", 32'(gnt), 32'd0);
    chk("rst.tx_load", 32'(tx_load), 32'd0);
    chk("rst.tx_data", 32'(tx_data), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.timeout_err", 32'(timeout_err), 32'd0);
    chk("rst.cfg", 32'(applied), 32'd0);
    rst = 1'b0; req = 4'b0000;
    @(negedge clk);
    chk("rst.cfg_capture", 32'(applied), 32'h5B);
    last_m = 3; err_m = 1'b0;

    // tx_done while idle with no request changes nothing.
    for (int i = 0; i < 3; i++) begin
      tx_done = (i != 1);
      @(negedge clk);
      chk("idle_done.out", 32'({busy, tx_load, gnt}), 32'd0);
    end
    tx_done = 1'b0;

    for (int i = 0; i < 10; i++) begin
      do_frame(tbl[i].r, tbl[i].d, tbl[i].dly, -1, 0, tbl[i].exp_g, tbl[i].exp_b,
               $sformatf("tbl%0d", i));
    end

    // Baud change mid-frame applies only once back in IDLE.
    cfg_baud = 4'b1011;
    @(negedge clk);
    chk("cfg.pre", 32'(baud), 32'hB);
    do_frame(4'b0100, 32'h00AB_0000, 4, -1, 2, 4'b0100, 8'hAB, "cfg_freeze");
    chk("cfg.post", 32'(baud), 32'h3);

    // Timeout sets the sticky flag; err_clr clears it.
    do_frame(4'b0010, 32'h0000_5500, -1, -1, 0, 4'b0010, 8'h55, "timeout");
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    err_m = 1'b0;
    chk("err_clr", 32'(timeout_err), 32'd0);
    // err_clr on the very timeout edge loses to the set.
    do_frame(4'b1000, 32'h6600_0000, -1, TIMEOUT, 0, 4'b1000, 8'h66, "set_wins");

    // Reset in the middle of WAIT_DONE.
    req = 4'b0001; req_data = 32'h0000_0077;
    @(negedge clk);
    chk("midrst.gnt", 32'(gnt), 32'h1);
    req = 4'b0000;
    repeat (3) @(negedge clk);
    rst = 1'b1; req = 4'b1111;
    @(negedge clk);
    chk("midrst.out", 32'({busy, tx_load, gnt}), 32'd0);
    chk("midrst.tx_data", 32'(tx_data), 32'd0);
    chk("midrst.timeout_err", 32'(timeout_err), 32'd0);
    chk("midrst.cfg", 32'(applied), 32'd0);
    rst = 1'b0;
    last_m = 3; err_m = 1'b0;
    do_frame(4'b1111, 32'hDDCC_BBAA, 1, -1, 1, 4'b0001, 8'hAA, "post_rst");

    // Random frames against the reference model.
    for (int n = 0; n < 40; n++) begin
      logic [3:0]  r;
      logic [31:0] d;
      int          dly, clr_at, w, gap;
      r   = 4'($urandom_range(1, 15));
      d   = $urandom;
      dly = $urandom_range(0, 9);
      if (dly == 9) dly = -1;
      clr_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, frame_len(dly) - 1) : -1;
      w = rr_model(r, last_m);
      do_frame(r, d, dly, clr_at, 1, 4'(1 << w), d[8*w +: 8], $sformatf("rnd%0d", n));
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        tx_done = 1'($urandom);
        @(negedge clk);
        chk("rnd.idle", 32'({busy, tx_load, gnt}), 32'd0);
      end
      tx_done = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
